timer_pwm_regs_core: RTL



---
 rtl/timer_pwm_regs_core.sv | 97 +++++++++
 1 files changed

// File: rtl/timer_pwm_regs_core.sv
// timer_pwm_regs_core: CTRL/PERIOD/DUTY/STATUS register bank driving a prescaled PWM counter with wrap IRQ.
// Optional macro TIMER_ONESHOT_EN makes CTRL[1] a stop-on-first-wrap control.
module timer_pwm_regs_core #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  pwm_out,
    output logic                  irq
);
    localparam logic [1:0] A_CTRL = 2'd0, A_PERIOD = 2'd1, A_DUTY = 2'd2;

    logic                 en_q, en_d, irq_en_q, irq_en_d, oneshot_q;
    logic [7:0]           presc_q, presc_d, psc_q, psc_d;
    logic [CNT_WIDTH-1:0] per_q, per_d, duty_q, duty_d;
    logic [CNT_WIDTH-1:0] per_act_q, per_act_d, duty_act_q, duty_act_d, cnt_q, cnt_d;
    logic                 wrap_q, wrap_d, pwm_q, pwm_d;
    logic                 wr_ctrl, wr_stat, tick, wrap, reload;
    logic                 unused_ok;

    assign wr_ctrl = wr_en && wr_addr[3:2] == A_CTRL;
    assign wr_stat = wr_en && wr_addr[3:2] == 2'd3;
    // >= rather than == so lowering PRESCALE mid-count cannot stall the prescaler for 256 cycles
    assign tick    = psc_q >= presc_q;
    assign wrap    = en_q && tick && cnt_q == per_act_q;
    assign reload  = !en_q || wrap;

    always_comb begin
        en_d       = (wrap && oneshot_q) ? 1'b0 : wr_ctrl ? wr_data[0] : en_q;
        irq_en_d   = wr_ctrl ? wr_data[2] : irq_en_q;
        presc_d    = wr_ctrl ? wr_data[15:8] : presc_q;
        per_d      = (wr_en && wr_addr[3:2] == A_PERIOD) ? wr_data[CNT_WIDTH-1:0] : per_q;
        duty_d     = (wr_en && wr_addr[3:2] == A_DUTY) ? wr_data[CNT_WIDTH-1:0] : duty_q;
        wrap_d     = wrap || (wrap_q && !(wr_stat && wr_data[0]));
        pwm_d      = en_q && cnt_q < duty_act_q;
        psc_d      = (!en_q || tick) ? 8'd0 : psc_q + 8'd1;
        cnt_d      = reload ? '0 : tick ? cnt_q + CNT_WIDTH'(1) : cnt_q;
        per_act_d  = reload ? per_q : per_act_q;
        duty_act_d = reload ? duty_q : duty_act_q;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            en_q       <= 1'b0;
            irq_en_q   <= 1'b0;
            presc_q    <= 8'd0;
            psc_q      <= 8'd0;
            per_q      <= '0;
            duty_q     <= '0;
            per_act_q  <= '0;
            duty_act_q <= '0;
            cnt_q      <= '0;
            wrap_q     <= 1'b0;
            pwm_q      <= 1'b0;
        end else begin
            en_q       <= en_d;
            irq_en_q   <= irq_en_d;
            presc_q    <= presc_d;
            psc_q      <= psc_d;
            per_q      <= per_d;
            duty_q     <= duty_d;
            per_act_q  <= per_act_d;
            duty_act_q <= duty_act_d;
            cnt_q      <= cnt_d;
            wrap_q     <= wrap_d;
            pwm_q      <= pwm_d;
        end
    end

`ifdef TIMER_ONESHOT_EN
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) oneshot_q <= 1'b0;
        else oneshot_q <= wr_ctrl ? wr_data[1] : oneshot_q;
    end
`else
    assign oneshot_q = 1'b0;
`endif

    always_comb begin
        rd_data = rd_addr[3:2] == A_CTRL   ? DATA_WIDTH'({presc_q, 5'd0, irq_en_q, oneshot_q, en_q}) :
                  rd_addr[3:2] == A_PERIOD ? DATA_WIDTH'(per_q) :
                  rd_addr[3:2] == A_DUTY   ? DATA_WIDTH'(duty_q) :
                                             DATA_WIDTH'({cnt_q, 15'd0, wrap_q});
    end

    assign pwm_out   = pwm_q;
    assign irq       = wrap_q & irq_en_q;
    assign unused_ok = ^{rd_en, wr_data, wr_addr, rd_addr};
endmodule
